ccd2axis_mc: RTL and testbench

Parametrised successor of the single-tap CCD line converter: it turns a free-running multi-tap CCD line stream into an AXI4-Stream video stream (tuser = start of frame, tlast = end of line). Dummy-pixel counts, effective width and frame height are run-time registers, not elaboration constants. An output FIFO absorbs downstream backpressure. The block sits between the CCD AFE capture logic and the VDMA/video pipeline on the `pixel_clk` domain.

---
 rtl/ccd_pkg.sv | 35 +++
 rtl/ccd_axis_fifo.sv | 78 +++++++
 rtl/ccd2axis_mc.sv | 160 ++++++++++++++++
 tb/tb_ccd2axis_mc.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ccd_pkg.sv
// rtl/ccd_pkg.sv - shared types, default widths and segment sequencing for ccd2axis_mc
package ccd_pkg;

   localparam int DEF_DATA_WIDTH = 8;
   localparam int DEF_TAPS       = 1;
   localparam int DEF_COLS_W     = 13;
   localparam int DEF_ROWS_W     = 12;
   localparam int DEF_FIFO_DEPTH = 16;

   typedef enum logic [1:0] {IDLE, PRE, EFFECT, POST} line_state_e;

   // Per-beat sideband kept next to the pixel data in each FIFO entry
   typedef struct packed {
      logic tuser;
      logic tlast;
   } beat_flags_t;

   // Next segment of a line after `cur` ends, skipping segments with a zero count.
   // From IDLE this gives the first segment of a new line.
   function automatic line_state_e next_segment(input line_state_e cur,
                                                input logic pre_nz,
                                                input logic eff_nz,
                                                input logic post_nz);
      line_state_e nxt;
      nxt = IDLE;
      case (cur)
         IDLE:    if (pre_nz) nxt = PRE; else if (eff_nz) nxt = EFFECT; else if (post_nz) nxt = POST;
         PRE:     if (eff_nz) nxt = EFFECT; else if (post_nz) nxt = POST;
         EFFECT:  if (post_nz) nxt = POST;
         default: nxt = IDLE;
      endcase
      return nxt;
   endfunction

endpackage

// File: rtl/ccd_axis_fifo.sv
// rtl/ccd_axis_fifo.sv - first-word-fall-through beat FIFO with registered outputs
// Entries are {tuser, tlast, data}. The output register counts toward DEPTH.
// A pushed beat lands in the array first and reaches the output one cycle later.
// patch_last forces tlast on the newest entry still in the array.
module ccd_axis_fifo
   import ccd_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int DEPTH = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  beat_flags_t      push_flags,
   input  logic             patch_last,
   output logic             full,
   output logic [WIDTH-1:0] m_data,
   output logic             m_valid,
   output logic             m_last,
   output logic             m_user,
   input  logic             m_ready
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem_data  [DEPTH];
   beat_flags_t      mem_flags [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [AW:0]      mem_cnt;
   logic [AW:0]      total;
   logic             pop;
   logic             push_ok;
   logic             load;

   assign total   = mem_cnt + (AW+1)'(m_valid);
   assign full    = (total == (AW+1)'(DEPTH));
   assign pop     = m_valid & m_ready;
   assign push_ok = push & (~full | pop);
   assign load    = (~m_valid | pop) & (mem_cnt != '0);

   // Storage array: write new beats, or repair tlast of the newest stored beat
   always_ff @(posedge clk) begin
      if (push_ok) begin
         mem_data[wr_ptr]  <= push_data;
         mem_flags[wr_ptr] <= push_flags;
      end else if (patch_last && mem_cnt != '0) begin
         mem_flags[wr_ptr - AW'(1)].tlast <= 1'b1;
      end
   end

   // Pointers, occupancy and the registered output stage
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         mem_cnt <= '0;
         m_valid <= 1'b0;
         m_data  <= '0;
         m_last  <= 1'b0;
         m_user  <= 1'b0;
      end else begin
         if (push_ok) wr_ptr <= wr_ptr + AW'(1);
         if (load) begin
            rd_ptr  <= rd_ptr + AW'(1);
            m_data  <= mem_data[rd_ptr];
            m_last  <= mem_flags[rd_ptr].tlast;
            m_user  <= mem_flags[rd_ptr].tuser;
            m_valid <= 1'b1;
         end else if (pop) begin
            m_valid <= 1'b0;
         end
         mem_cnt <= mem_cnt + (AW+1)'(push_ok) - (AW+1)'(load);
      end
   end

endmodule

// File: rtl/ccd2axis_mc.sv
// rtl/ccd2axis_mc.sv - multi-tap CCD line stream to AXI4-Stream video converter
// Optional build macro CCD2AXIS_MC_STATUS_EN: sticky overflow/line-error flags,
// sts_clr and tlast repair on dropped end-of-line beats.
module ccd2axis_mc
   import ccd_pkg::*;
#(
   parameter int DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int TAPS       = DEF_TAPS,
   parameter int COLS_W     = DEF_COLS_W,
   parameter int ROWS_W     = DEF_ROWS_W,
   parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
   input  logic                       pixel_clk,
   input  logic                       rst_n,
   input  logic                       tvalid,
   input  logic [TAPS*DATA_WIDTH-1:0] tdata,
   input  logic [COLS_W-1:0]          cfg_pre_dummy,
   input  logic [COLS_W-1:0]          cfg_effect_cols,
   input  logic [COLS_W-1:0]          cfg_post_dummy,
   input  logic [ROWS_W-1:0]          cfg_rows,
   output logic [TAPS*DATA_WIDTH-1:0] m_axis_tdata,
   output logic                       m_axis_tvalid,
   input  logic                       m_axis_tready,
   output logic                       m_axis_tlast,
   output logic                       m_axis_tuser,
   output logic                       sts_overflow,
   output logic                       sts_line_err,
   input  logic                       sts_clr
);

   localparam int BEAT_W = TAPS * DATA_WIDTH;

   logic              tvalid_d;
   logic [BEAT_W-1:0] tdata_d;
   line_state_e       state;
   line_state_e       seg_next;
   line_state_e       start_state;
   logic [COLS_W-1:0] cols;
   logic [COLS_W-1:0] pre_q;
   logic [COLS_W-1:0] eff_q;
   logic [COLS_W-1:0] post_q;
   logic [COLS_W-1:0] seg_len;
   logic [ROWS_W-1:0] row;
   logic [ROWS_W-1:0] rows_eff;
   logic              line_start;
   logic              seg_last;
   logic              line_ending;
   logic              busy;
   logic              push;
   logic              fifo_full;
   logic              patch_last;
   beat_flags_t       push_flags;

   // State and cols describe the beat held in tdata_d, one cycle behind the sensor.
   assign line_start  = tvalid & ~tvalid_d;
   assign rows_eff    = (cfg_rows == '0) ? ROWS_W'(1) : cfg_rows;
   assign seg_last    = (cols == seg_len - COLS_W'(1));
   assign seg_next    = next_segment(state, pre_q != '0, eff_q != '0, post_q != '0);
   assign start_state = next_segment(IDLE, cfg_pre_dummy != '0, cfg_effect_cols != '0,
                                     cfg_post_dummy != '0);
   // The last beat of a line is already on its way out, so a new edge there is legal
   assign line_ending = (state != IDLE) & seg_last & (seg_next == IDLE);
   assign busy        = (state != IDLE) & ~line_ending;

   // Length of the segment currently being counted
   always_comb begin
      seg_len = post_q;
      case (state)
         PRE:     seg_len = pre_q;
         EFFECT:  seg_len = eff_q;
         default: seg_len = post_q;
      endcase
   end

   // Line sequencer: input registers, config latch, segment FSM, column and row counters
   always_ff @(posedge pixel_clk or negedge rst_n) begin
      if (!rst_n) begin
         tvalid_d <= 1'b1;   // a line already in flight at reset release is not an edge
         tdata_d  <= '0;
         state    <= IDLE;
         cols     <= '0;
         pre_q    <= '0;
         eff_q    <= '0;
         post_q   <= '0;
         row      <= '0;
      end else begin
         tvalid_d <= tvalid;
         tdata_d  <= tdata;
         if (line_start && !busy) begin
            pre_q  <= cfg_pre_dummy;
            eff_q  <= cfg_effect_cols;
            post_q <= cfg_post_dummy;
            row    <= ({1'b0, row} >= {1'b0, rows_eff}) ? ROWS_W'(1) : row + ROWS_W'(1);
            state  <= start_state;
            cols   <= '0;
         end else if (state != IDLE) begin
            if (seg_last) begin
               state <= seg_next;
               cols  <= '0;
            end else begin
               cols <= cols + COLS_W'(1);
            end
         end
      end
   end

   assign push             = (state == EFFECT);
   assign push_flags.tuser = (row == ROWS_W'(1)) && (cols == '0);
   assign push_flags.tlast = seg_last;

`ifdef CCD2AXIS_MC_STATUS_EN
   logic pop;
   logic drop;
   logic line_err_set;

   assign pop          = m_axis_tvalid & m_axis_tready;
   assign drop         = push & fifo_full & ~pop;
   assign line_err_set = line_start & busy;
   assign patch_last   = drop & push_flags.tlast;

   // Sticky status flags; a set event beats a simultaneous clear
   always_ff @(posedge pixel_clk or negedge rst_n) begin
      if (!rst_n) begin
         sts_overflow <= 1'b0;
         sts_line_err <= 1'b0;
      end else begin
         if (drop)         sts_overflow <= 1'b1;
         else if (sts_clr) sts_overflow <= 1'b0;
         if (line_err_set) sts_line_err <= 1'b1;
         else if (sts_clr) sts_line_err <= 1'b0;
      end
   end
`else
   logic unused_status;

   assign unused_status = sts_clr ^ fifo_full;
   assign patch_last    = 1'b0;
   assign sts_overflow  = 1'b0;
   assign sts_line_err  = 1'b0;
`endif

   ccd_axis_fifo #(
      .WIDTH (BEAT_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk        (pixel_clk),
      .rst_n      (rst_n),
      .push       (push),
      .push_data  (tdata_d),
      .push_flags (push_flags),
      .patch_last (patch_last),
      .full       (fifo_full),
      .m_data     (m_axis_tdata),
      .m_valid    (m_axis_tvalid),
      .m_last     (m_axis_tlast),
      .m_user     (m_axis_tuser),
      .m_ready    (m_axis_tready)
   );

endmodule

// File: tb/tb_ccd2axis_mc.sv
// tb/tb_ccd2axis_mc.sv - directed self-checking bench for ccd2axis_mc (TAPS=2, FIFO_DEPTH=4)
module tb_ccd2axis_mc;

`ifdef CCD2AXIS_MC_STATUS_EN
   localparam bit STS = 1'b1;
`else
   localparam bit STS = 1'b0;
`endif

   logic        pixel_clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        tvalid = 1'b0;
   logic [15:0] tdata = '0;
   logic [12:0] cfg_pre_dummy = '0;
   logic [12:0] cfg_effect_cols = '0;
   logic [12:0] cfg_post_dummy = '0;
   logic [11:0] cfg_rows = '0;
   logic [15:0] m_axis_tdata;
   logic        m_axis_tvalid;
   logic        m_axis_tready = 1'b1;
   logic        m_axis_tlast;
   logic        m_axis_tuser;
   logic        sts_overflow;
   logic        sts_line_err;
   logic        sts_clr = 1'b0;

   int checks = 0;
   int failures = 0;
   int cyc = 0;
   int line_c0 = 0;

   logic [15:0] q_data [$];
   logic        q_user [$];
   logic        q_last [$];
   int          q_cyc  [$];

   ccd2axis_mc #(
      .DATA_WIDTH (8),
      .TAPS       (2),
      .COLS_W     (13),
      .ROWS_W     (12),
      .FIFO_DEPTH (4)
   ) dut (
      .pixel_clk       (pixel_clk),
      .rst_n           (rst_n),
      .tvalid          (tvalid),
      .tdata           (tdata),
      .cfg_pre_dummy   (cfg_pre_dummy),
      .cfg_effect_cols (cfg_effect_cols),
      .cfg_post_dummy  (cfg_post_dummy),
      .cfg_rows        (cfg_rows),
      .m_axis_tdata    (m_axis_tdata),
      .m_axis_tvalid   (m_axis_tvalid),
      .m_axis_tready   (m_axis_tready),
      .m_axis_tlast    (m_axis_tlast),
      .m_axis_tuser    (m_axis_tuser),
      .sts_overflow    (sts_overflow),
      .sts_line_err    (sts_line_err),
      .sts_clr         (sts_clr)
   );

   always #5 pixel_clk = ~pixel_clk;

   always @(posedge pixel_clk) cyc <= cyc + 1;

   // Record every completed output transfer (sampled mid-cycle)
   always @(negedge pixel_clk) begin
      if (rst_n && m_axis_tvalid && m_axis_tready) begin
         q_data.push_back(m_axis_tdata);
         q_user.push_back(m_axis_tuser);
         q_last.push_back(m_axis_tlast);
         q_cyc.push_back(cyc);
      end
   end

   task automatic step(input int n);
      repeat (n) begin
         @(posedge pixel_clk);
         #1;
      end
   endtask

   task automatic clear_q();
      q_data.delete();
      q_user.delete();
      q_last.delete();
      q_cyc.delete();
   endtask

   // One sensor line: tdata = {id, beat index}; optional tvalid dip, sts_clr pulse, mid-line effect change
   task automatic drive_line(input int id, input int pre, input int eff, input int post, input int gap,
                             input int drop_b, input int clr_b, input int chg_b, input int chg_eff);
      int len;
      len = pre + eff + post;
      if (len < 1) len = 1;
      cfg_pre_dummy   = 13'(pre);
      cfg_effect_cols = 13'(eff);
      cfg_post_dummy  = 13'(post);
      for (int k = 0; k < len; k++) begin
         tvalid  = (k == drop_b) ? 1'b0 : 1'b1;
         tdata   = {8'(id), 8'(k)};
         sts_clr = (k == clr_b);
         if (k == chg_b) cfg_effect_cols = 13'(chg_eff);
         if (k == 0) line_c0 = cyc + 1;
         step(1);
      end
      tvalid  = 1'b0;
      sts_clr = 1'b0;
      tdata   = '0;
      step(gap);
   endtask

   task automatic pulse_clr();
      sts_clr = 1'b1;
      step(1);
      sts_clr = 1'b0;
   endtask

   task automatic test_reset();
      step(1);
      checks++; if (m_axis_tvalid !== 1'b0) begin failures++; $display("FAIL reset_tvalid got=%b exp=0", m_axis_tvalid); end
      checks++; if (m_axis_tdata !== 16'h0) begin failures++; $display("FAIL reset_tdata got=%h exp=0000", m_axis_tdata); end
      checks++; if (m_axis_tlast !== 1'b0 || m_axis_tuser !== 1'b0) begin failures++; $display("FAIL reset_flags got=%b%b exp=00", m_axis_tlast, m_axis_tuser); end
      checks++; if (sts_overflow !== 1'b0 || sts_line_err !== 1'b0) begin failures++; $display("FAIL reset_sts got=%b%b exp=00", sts_overflow, sts_line_err); end
      rst_n = 1'b1;
      step(3);
      checks++; if (m_axis_tvalid !== 1'b0) begin failures++; $display("FAIL post_reset_tvalid got=%b exp=0", m_axis_tvalid); end
   endtask

   task automatic test_nominal();
      bit exp_user [4];
      exp_user = '{1'b1, 1'b0, 1'b0, 1'b1};
      m_axis_tready = 1'b1;
      cfg_rows = 12'd3;
      for (int ln = 0; ln < 4; ln++) begin
         clear_q();
         drive_line(16 + ln, 4, 8, 2, 10, -1, -1, -1, 0);
         checks++;
         if (q_data.size() != 8) begin
            failures++; $display("FAIL nominal_count line=%0d got=%0d exp=8", ln, q_data.size());
         end else begin
            for (int i = 0; i < 8; i++) begin
               checks++; if (q_data[i] !== {8'(16 + ln), 8'(4 + i)}) begin failures++; $display("FAIL nominal_data line=%0d beat=%0d got=%h exp=%h", ln, i, q_data[i], {8'(16 + ln), 8'(4 + i)}); end
               checks++; if (q_user[i] !== (exp_user[ln] && i == 0)) begin failures++; $display("FAIL nominal_tuser line=%0d beat=%0d got=%b exp=%b", ln, i, q_user[i], exp_user[ln] && i == 0); end
               checks++; if (q_last[i] !== (i == 7)) begin failures++; $display("FAIL nominal_tlast line=%0d beat=%0d got=%b exp=%b", ln, i, q_last[i], i == 7); end
            end
            if (ln == 0) begin
               checks++; if (q_cyc[0] != line_c0 + 6) begin failures++; $display("FAIL nominal_latency got=%0d exp=%0d", q_cyc[0] - line_c0, 6); end
               checks++; if (q_cyc[7] != q_cyc[0] + 7) begin failures++; $display("FAIL nominal_throughput got=%0d exp=7", q_cyc[7] - q_cyc[0]); end
            end
         end
      end
   endtask

   task automatic test_zero_counts();
      m_axis_tready = 1'b1;
      cfg_rows = 12'd1;
      clear_q();
      drive_line(8'h30, 0, 1, 0, 8, -1, -1, -1, 0);
      checks++;
      if (q_data.size() != 1) begin
         failures++; $display("FAIL zero_e1_count got=%0d exp=1", q_data.size());
      end else begin
         checks++; if (q_data[0] !== 16'h3000) begin failures++; $display("FAIL zero_e1_data got=%h exp=3000", q_data[0]); end
         checks++; if (q_user[0] !== 1'b1 || q_last[0] !== 1'b1) begin failures++; $display("FAIL zero_e1_flags got=%b%b exp=11", q_user[0], q_last[0]); end
         checks++; if (q_cyc[0] != line_c0 + 2) begin failures++; $display("FAIL zero_e1_latency got=%0d exp=2", q_cyc[0] - line_c0); end
      end
      clear_q();
      drive_line(8'h31, 0, 0, 0, 8, -1, -1, -1, 0);
      checks++; if (q_data.size() != 0) begin failures++; $display("FAIL zero_e0_count got=%0d exp=0", q_data.size()); end
      clear_q();
      drive_line(8'h32, 0, 1, 0, 8, -1, -1, -1, 0);
      checks++;
      if (q_data.size() != 1) begin
         failures++; $display("FAIL zero_after_idle_count got=%0d exp=1", q_data.size());
      end else begin
         checks++; if (q_data[0] !== 16'h3200) begin failures++; $display("FAIL zero_after_idle_data got=%h exp=3200", q_data[0]); end
      end
   endtask

   task automatic test_backpressure();
      cfg_rows = 12'd1;
      m_axis_tready = 1'b0;
      clear_q();
      drive_line(8'h40, 1, 8, 1, 4, -1, -1, -1, 0);
      checks++; if (sts_overflow !== STS) begin failures++; $display("FAIL bp_overflow got=%b exp=%b", sts_overflow, STS); end
      for (int s = 0; s < 3; s++) begin
         checks++; if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== 16'h4001) begin failures++; $display("FAIL bp_stall_hold cyc=%0d got=%b/%h exp=1/4001", s, m_axis_tvalid, m_axis_tdata); end
         checks++; if (m_axis_tuser !== 1'b1 || m_axis_tlast !== 1'b0) begin failures++; $display("FAIL bp_stall_flags cyc=%0d got=%b%b exp=10", s, m_axis_tuser, m_axis_tlast); end
         step(1);
      end
      m_axis_tready = 1'b1;
      step(8);
      checks++;
      if (q_data.size() != 4) begin
         failures++; $display("FAIL bp_count got=%0d exp=4", q_data.size());
      end else begin
         for (int i = 0; i < 4; i++) begin
            checks++; if (q_data[i] !== {8'h40, 8'(1 + i)}) begin failures++; $display("FAIL bp_data beat=%0d got=%h exp=%h", i, q_data[i], {8'h40, 8'(1 + i)}); end
            checks++; if (q_last[i] !== (STS && i == 3)) begin failures++; $display("FAIL bp_tlast beat=%0d got=%b exp=%b", i, q_last[i], STS && i == 3); end
            checks++; if (q_user[i] !== (i == 0)) begin failures++; $display("FAIL bp_tuser beat=%0d got=%b exp=%b", i, q_user[i], i == 0); end
         end
      end
      checks++; if (m_axis_tvalid !== 1'b0) begin failures++; $display("FAIL bp_drained got=%b exp=0", m_axis_tvalid); end
      pulse_clr();
      checks++; if (sts_overflow !== 1'b0) begin failures++; $display("FAIL bp_clr got=%b exp=0", sts_overflow); end
   endtask

   task automatic test_line_err();
      m_axis_tready = 1'b1;
      cfg_rows = 12'd1;
      clear_q();
      drive_line(8'h50, 0, 8, 0, 8, 2, -1, -1, 0);
      checks++; if (sts_line_err !== STS) begin failures++; $display("FAIL lerr_flag got=%b exp=%b", sts_line_err, STS); end
      checks++;
      if (q_data.size() != 8) begin
         failures++; $display("FAIL lerr_count got=%0d exp=8", q_data.size());
      end else begin
         for (int i = 0; i < 8; i++) begin
            checks++; if (q_data[i] !== {8'h50, 8'(i)} || q_last[i] !== (i == 7)) begin failures++; $display("FAIL lerr_beat beat=%0d got=%h/%b exp=%h/%b", i, q_data[i], q_last[i], {8'h50, 8'(i)}, i == 7); end
         end
      end
      pulse_clr();
      checks++; if (sts_line_err !== 1'b0) begin failures++; $display("FAIL lerr_clr got=%b exp=0", sts_line_err); end
      drive_line(8'h51, 0, 8, 0, 8, 1, 2, -1, 0);
      checks++; if (sts_line_err !== STS) begin failures++; $display("FAIL lerr_set_wins got=%b exp=%b", sts_line_err, STS); end
   endtask

   task automatic test_cfg_latch();
      m_axis_tready = 1'b1;
      cfg_rows = 12'd1;
      clear_q();
      drive_line(8'h60, 2, 8, 2, 8, -1, -1, 3, 4);
      checks++;
      if (q_data.size() != 8) begin
         failures++; $display("FAIL latch_cur_count got=%0d exp=8", q_data.size());
      end else begin
         checks++; if (q_data[7] !== 16'h6009 || q_last[7] !== 1'b1) begin failures++; $display("FAIL latch_cur_last got=%h/%b exp=6009/1", q_data[7], q_last[7]); end
      end
      clear_q();
      drive_line(8'h61, 2, 4, 2, 8, -1, -1, -1, 0);
      checks++;
      if (q_data.size() != 4) begin
         failures++; $display("FAIL latch_next_count got=%0d exp=4", q_data.size());
      end else begin
         checks++; if (q_data[3] !== 16'h6105 || q_last[3] !== 1'b1) begin failures++; $display("FAIL latch_next_last got=%h/%b exp=6105/1", q_data[3], q_last[3]); end
      end
   endtask

   task automatic test_reset_midline();
      m_axis_tready = 1'b1;
      cfg_rows = 12'd1;
      cfg_pre_dummy = 13'd0;
      cfg_effect_cols = 13'd8;
      cfg_post_dummy = 13'd0;
      tvalid = 1'b1;
      for (int k = 0; k < 5; k++) begin
         tdata = {8'h70, 8'(k)};
         step(1);
      end
      tdata = 16'h7005;
      rst_n = 1'b0;
      #1;
      checks++; if (m_axis_tvalid !== 1'b0 || m_axis_tdata !== 16'h0) begin failures++; $display("FAIL rstmid_out got=%b/%h exp=0/0000", m_axis_tvalid, m_axis_tdata); end
      checks++; if (m_axis_tlast !== 1'b0 || m_axis_tuser !== 1'b0) begin failures++; $display("FAIL rstmid_flags got=%b%b exp=00", m_axis_tlast, m_axis_tuser); end
      checks++; if (sts_overflow !== 1'b0 || sts_line_err !== 1'b0) begin failures++; $display("FAIL rstmid_sts got=%b%b exp=00", sts_overflow, sts_line_err); end
      clear_q();
      step(2);
      rst_n = 1'b1;
      step(12);
      checks++; if (q_data.size() != 0 || m_axis_tvalid !== 1'b0) begin failures++; $display("FAIL rstmid_skip got=%0d/%b exp=0/0", q_data.size(), m_axis_tvalid); end
      tvalid = 1'b0;
      step(2);
      clear_q();
      drive_line(8'h71, 0, 8, 0, 8, -1, -1, -1, 0);
      checks++;
      if (q_data.size() != 8) begin
         failures++; $display("FAIL rstmid_next_count got=%0d exp=8", q_data.size());
      end else begin
         checks++; if (q_data[0] !== 16'h7100 || q_user[0] !== 1'b1) begin failures++; $display("FAIL rstmid_next_first got=%h/%b exp=7100/1", q_data[0], q_user[0]); end
      end
   endtask

   initial begin
      test_reset();
      test_nominal();
      test_zero_counts();
      test_backpressure();
      test_line_err();
      test_cfg_latch();
      test_reset_midline();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog time limit reached");
      $fatal(1);
   end

endmodule
